sequential_divider: RTL

Multi-cycle signed 32-bit integer divider, the counterpart to the combinational Booth bit-pair multiplier in the ALU datapath. It takes a dividend and a divisor, runs a non-restoring division over the operand magnitudes, then fixes the signs. It returns the quotient (destined for LO) and the remainder (destined for HI). A start/busy/done handshake lets the control unit stall while the operation completes.

---
 rtl/sequential_divider.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// sequential_divider: multi-cycle signed integer divider (non-restoring core).
// Quotient (truncated toward zero) goes to LO and remainder (sign of dividend)
// goes to HI. A start/busy/done handshake lets the control unit stall while an
// operation is in flight. A normal division takes BITS+2 edges from the
// accepting edge to the return to IDLE.
//
// Build option:
//   DIVIDER_ZERO_TRAP_EN  - a zero divisor is trapped at the accepting edge:
//                           done pulses the next cycle with div_zero=1,
//                           quotient=all ones, remainder=dividend, and busy
//                           never rises. Without it a zero divisor runs the
//                           normal path, its results are meaningless, and
//                           div_zero is tied low.

module sequential_divider #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic [BITS-1:0] dividend,
   input  logic [BITS-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] quotient,
   output logic [BITS-1:0] remainder,
   output logic            div_zero
);

   localparam int CNT_W = $clog2(BITS) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ITERATE = 2'd1,
      CORRECT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [BITS:0]    p_reg;      // signed partial remainder, one guard bit
   logic [BITS-1:0]  q_reg;      // quotient shift register (starts as |dividend|)
   logic [BITS-1:0]  d_reg;      // |divisor|
   logic             neg_q;
   logic             neg_r;

   logic [BITS-1:0]  dividend_mag;
   logic [BITS-1:0]  divisor_mag;
   logic [BITS:0]    p_shift;
   logic [BITS:0]    p_step;
   logic [BITS-1:0]  q_step;
   logic [BITS:0]    p_fix;
   logic [BITS-1:0]  q_signed;
   logic [BITS-1:0]  r_signed;

   // Operand magnitudes; -2^(BITS-1) maps onto itself and is read as unsigned.
   always_comb begin
      dividend_mag = dividend[BITS-1] ? (~dividend + 1'b1) : dividend;
      divisor_mag  = divisor[BITS-1]  ? (~divisor + 1'b1)  : divisor;
   end

   // One non-restoring step, the final remainder fix-up and the sign fix-up.
   always_comb begin
      // NOTE: every signal gets a value before any branch so no latch is inferred.
      p_shift = {p_reg[BITS-1:0], q_reg[BITS-1]};
      p_step  = p_shift;
      if (!p_reg[BITS]) begin
         p_step = p_shift - {1'b0, d_reg};
      end else begin
         p_step = p_shift + {1'b0, d_reg};
      end
      q_step = {q_reg[BITS-2:0], ~p_step[BITS]};

      p_fix = p_reg;
      if (p_reg[BITS]) begin
         p_fix = p_reg + {1'b0, d_reg};
      end

      q_signed = neg_q ? (~q_reg + 1'b1) : q_reg;
      r_signed = neg_r ? (~p_fix[BITS-1:0] + 1'b1) : p_fix[BITS-1:0];
   end

`ifdef DIVIDER_ZERO_TRAP_EN
   logic div_zero_q;
   assign div_zero = div_zero_q;
`else
   assign div_zero = 1'b0;
`endif

   // Control FSM with datapath registers and registered handshake/results.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!clr) begin
         state     <= IDLE;
         count     <= '0;
         p_reg     <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIVIDER_ZERO_TRAP_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  q_reg <= dividend_mag;
                  d_reg <= divisor_mag;
                  p_reg <= '0;
                  neg_q <= dividend[BITS-1] ^ divisor[BITS-1];
                  neg_r <= dividend[BITS-1];
                  count <= '0;
                  busy  <= 1'b1;
                  state <= ITERATE;
`ifdef DIVIDER_ZERO_TRAP_EN
                  // A zero divisor overrides the normal launch and finishes at once.
                  div_zero_q <= (divisor == '0);
                  if (divisor == '0) begin
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                     state     <= DONE;
                  end
`endif
               end
            end

            ITERATE: begin
               p_reg <= p_step;
               q_reg <= q_step;
               count <= count + CNT_W'(1);
               if (count == CNT_W'(BITS - 1)) begin
                  state <= CORRECT;
               end
            end

            CORRECT: begin
               p_reg     <= p_fix;
               quotient  <= q_signed;
               remainder <= r_signed;
               busy      <= 1'b0;
               done      <= 1'b1;
               state     <= DONE;
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
